// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack bus-crossing blocks.
// Holds the handshake state encoding, the default synchronizer depth
// and the sizing helper for the optional phase timeout counter.
package cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } cdc_state_e;

  localparam int CDC_SYNC_STAGES_DEF = 2;

  // Bits needed to count up to and including timeout_cycles.
  function automatic int cdc_timeout_cnt_bits(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer.
// Brings an asynchronous level into the clk_des domain through a
// SYNC_STAGES-deep chain; every chain flop is marked ASYNC_REG so
// implementation keeps them adjacent and out of retiming.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
  input  logic clk_des,
  input  logic reset,
  input  logic d_async,
  output logic q_sync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain_r;

  // Shift the asynchronous level through the synchronizer chain.
  always_ff @(posedge clk_des or posedge reset) begin
    if (reset) begin
      chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d_async};
    end
  end

  assign q_sync = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_src.sv
// Source-domain end of a 4-phase req/ack bus crossing.
// A word accepted from the source is held on data_des while req_des
// is raised; the synchronized ack closes the request, and the next
// word is accepted only after ack has fallen again (done pulses then).
// Optional: define CDC_HS_TIMEOUT_EN to abort a handshake phase that
// lasts TIMEOUT_CYCLES cycles and raise the sticky timeout_err flag.
module cdc_handshake_src
  import cdc_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int SYNC_STAGES    = CDC_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_src,
  input  logic                 reset,
  input  logic                 src_valid,
  input  logic [DATA_BITS-1:0] src_data,
  output logic                 src_ready,
  output logic                 req_des,
  output logic [DATA_BITS-1:0] data_des,
  input  logic                 ack_des,
  output logic                 done
`ifdef CDC_HS_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] REQ     = ST_REQ;
  localparam logic [1:0] RELEASE = ST_RELEASE;

  // Reject configurations the synchronizer or the timeout cannot support.
  generate
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("cdc_handshake_src: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic                 req_des_r;
  logic                 req_nxt_s;
  logic [DATA_BITS-1:0] data_des_r;
  logic [DATA_BITS-1:0] data_nxt_s;
  logic                 done_r;
  logic                 done_nxt_s;
  logic                 ack_sync_s;
  logic                 accept_s;
  logic                 abort_s;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_des (clk_src),
    .reset   (reset),
    .d_async (ack_des),
    .q_sync  (ack_sync_s)
  );

  // A stale ack seen in IDLE keeps the source blocked until it clears.
  assign src_ready = (state_r == IDLE) && !ack_sync_s;
  assign accept_s  = src_valid && src_ready;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int             CNT_W    = cdc_timeout_cnt_bits(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] phase_cnt_r;
  logic             timeout_err_r;

  // Abort only when the phase would otherwise continue past its budget.
  assign abort_s = (phase_cnt_r == CNT_LAST) &&
                   (((state_r == REQ) && !ack_sync_s) ||
                    ((state_r == RELEASE) && ack_sync_s));

  // Count cycles spent in the current handshake phase.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      phase_cnt_r <= {CNT_W{1'b0}};
    end else if (state_nxt_s != state_r) begin
      phase_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != IDLE) begin
      phase_cnt_r <= phase_cnt_r + CNT_W'(1'b1);
    end else begin
      phase_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Latch a phase timeout until the next reset.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (abort_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and output decode for the 4-phase handshake.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_des_r;
    data_nxt_s  = data_des_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ;
          req_nxt_s   = 1'b1;
          data_nxt_s  = src_data;
        end else begin
          req_nxt_s   = 1'b0;
        end
      end
      REQ: begin
        if (ack_sync_s) begin
          state_nxt_s = RELEASE;
          req_nxt_s   = 1'b0;
        end else if (abort_s) begin
          state_nxt_s = IDLE;
          req_nxt_s   = 1'b0;
        end else begin
          req_nxt_s   = 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_sync_s) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else if (abort_s) begin
          state_nxt_s = IDLE;
        end else begin
          req_nxt_s   = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // Handshake state and registered outputs.
  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      req_des_r  <= 1'b0;
      data_des_r <= {DATA_BITS{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      req_des_r  <= req_nxt_s;
      data_des_r <= data_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign req_des  = req_des_r;
  assign data_des = data_des_r;
  assign done     = done_r;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Self-checking bench for cdc_handshake_src.
// Expected timing is computed from the handshake rules (accept edge,
// SYNC_STAGES synchronizer delay, one edge to react); expected words
// come from a queue of words offered and accepted by the source.
module tb_cdc_handshake_src;

  localparam int DATA_BITS      = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic                 clk_src = 1'b0;
  logic                 reset;
  logic                 src_valid;
  logic [DATA_BITS-1:0] src_data;
  logic                 src_ready;
  logic                 req_des;
  logic [DATA_BITS-1:0] data_des;
  logic                 ack_des;
  logic                 done;
`ifdef CDC_HS_TIMEOUT_EN
  logic                 timeout_err;
`endif

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [DATA_BITS-1:0] exp_q[$];

  cdc_handshake_src #(
    .DATA_BITS      (DATA_BITS),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_src   (clk_src),
    .reset     (reset),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .req_des   (req_des),
    .data_des  (data_des),
    .ack_des   (ack_des),
    .done      (done)
`ifdef CDC_HS_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk_src = ~clk_src;

  // Count completion pulses seen on the falling edge.
  always @(negedge clk_src) begin
    if (reset === 1'b0 && done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_src);
  endtask

  // One full handshake starting in IDLE at a falling edge. If hold_valid
  // is set, next_w is offered throughout and stays offered at the end.
  task automatic xfer(input logic [DATA_BITS-1:0] w, input int d, input int r,
                      input logic hold_valid, input logic [DATA_BITS-1:0] next_w);
    src_valid = 1'b1;
    src_data  = w;
    exp_q.push_back(w);
    step(1);
    chk("acc_req", {31'd0, req_des}, 32'd1);
    chk("acc_data", {24'd0, data_des}, {24'd0, w});
    chk("acc_ready", {31'd0, src_ready}, 32'd0);
    chk("acc_done_low", {31'd0, done}, 32'd0);
    src_valid = hold_valid;
    src_data  = hold_valid ? next_w : 8'hFF;
    for (int i = 0; i < d; i++) begin
      if (!hold_valid) src_valid = 1'($urandom_range(0, 1));
      step(1);
      chk("req_hold", {31'd0, req_des}, 32'd1);
      chk("data_hold", {24'd0, data_des}, {24'd0, w});
      chk("blocked_ready", {31'd0, src_ready}, 32'd0);
    end
    ack_des = 1'b1;
    step(SYNC_STAGES);
    chk("req_before_sync", {31'd0, req_des}, 32'd1);
    step(1);
    chk("req_fall", {31'd0, req_des}, 32'd0);
    chk("rel_ready", {31'd0, src_ready}, 32'd0);
    for (int i = 0; i < r; i++) begin
      step(1);
      chk("rel_done_low", {31'd0, done}, 32'd0);
      chk("rel_data", {24'd0, data_des}, {24'd0, w});
    end
    ack_des = 1'b0;
    step(SYNC_STAGES);
    chk("done_early", {31'd0, done}, 32'd0);
    step(1);
    exp_done++;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_ready", {31'd0, src_ready}, 32'd1);
    chk("done_req", {31'd0, req_des}, 32'd0);
    chk("done_word", {24'd0, data_des}, {24'd0, exp_q.pop_front()});
    if (!hold_valid) src_valid = 1'b0;
  endtask

  initial begin
    logic [DATA_BITS-1:0] w;
    reset     = 1'b1;
    src_valid = 1'b0;
    src_data  = 8'h00;
    ack_des   = 1'b0;
    step(2);
    chk("rst_req", {31'd0, req_des}, 32'd0);
    chk("rst_data", {24'd0, data_des}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, src_ready}, 32'd1);
`ifdef CDC_HS_TIMEOUT_EN
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
`endif
    reset = 1'b0;
    step(1);

    // Single transfer, ack after 5 cycles.
    xfer(8'hA5, 5, 3, 1'b0, 8'h00);
    step(2);
    chk("idle_data_held", {24'd0, data_des}, 32'h0000_00A5);
    chk("idle_ready", {31'd0, src_ready}, 32'd1);
    chk("idle_done_low", {31'd0, done}, 32'd0);

    // Back-to-back with src_valid held high; blocked words must wait.
    xfer(8'h01, 2, 1, 1'b1, 8'h02);
    xfer(8'h02, 0, 0, 1'b1, 8'h03);
    xfer(8'h03, 1, 2, 1'b1, 8'hFF);
    xfer(8'hFF, 0, 1, 1'b0, 8'h00);
    chk("b2b_queue_empty", exp_q.size(), 32'd0);

    // Randomized words, ack/release delays and idle gaps.
    for (int k = 0; k < 12; k++) begin
      w = DATA_BITS'($urandom);
      xfer(w, $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, 8'h00);
      step($urandom_range(0, 3));
      chk("gap_ready", {31'd0, src_ready}, 32'd1);
      chk("gap_data", {24'd0, data_des}, {24'd0, w});
    end

    // Stale ack present at reset release blocks the source.
    reset   = 1'b1;
    ack_des = 1'b1;
    step(2);
    reset = 1'b0;
    step(SYNC_STAGES);
    src_valid = 1'b1;
    src_data  = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stale_ready", {31'd0, src_ready}, 32'd0);
      chk("stale_req", {31'd0, req_des}, 32'd0);
    end
    ack_des = 1'b0;
    step(SYNC_STAGES);
    chk("stale_clear_ready", {31'd0, src_ready}, 32'd1);
    chk("stale_clear_req", {31'd0, req_des}, 32'd0);
    step(1);
    chk("stale_accept_req", {31'd0, req_des}, 32'd1);
    chk("stale_accept_data", {24'd0, data_des}, 32'h0000_003C);
    src_valid = 1'b0;
    ack_des   = 1'b1;
    step(SYNC_STAGES + 1);
    chk("stale_req_fall", {31'd0, req_des}, 32'd0);
    ack_des = 1'b0;
    step(SYNC_STAGES + 1);
    exp_done++;
    chk("stale_done", {31'd0, done}, 32'd1);

    // Asynchronous reset in the middle of REQ.
    step(1);
    src_valid = 1'b1;
    src_data  = 8'h5A;
    step(1);
    chk("mid_req_up", {31'd0, req_des}, 32'd1);
    src_valid = 1'b0;
    step(1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, req_des}, 32'd0);
    chk("mid_rst_data", {24'd0, data_des}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("mid_rst_ready", {31'd0, src_ready}, 32'd1);
    xfer(8'hC3, 1, 1, 1'b0, 8'h00);

`ifdef CDC_HS_TIMEOUT_EN
    // Responder never acks: the REQ phase aborts after TIMEOUT_CYCLES.
    step(1);
    src_valid = 1'b1;
    src_data  = 8'h77;
    step(1);
    src_valid = 1'b0;
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      step(1);
      chk("to_req_hold", {31'd0, req_des}, 32'd1);
      chk("to_err_low", {31'd0, timeout_err}, 32'd0);
    end
    step(1);
    chk("to_req_drop", {31'd0, req_des}, 32'd0);
    chk("to_err_set", {31'd0, timeout_err}, 32'd1);
    chk("to_no_done", {31'd0, done}, 32'd0);
    chk("to_ready", {31'd0, src_ready}, 32'd1);
    step(3);
    chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
    xfer(8'h4E, 2, 2, 1'b0, 8'h00);
    chk("to_err_sticky2", {31'd0, timeout_err}, 32'd1);
    reset = 1'b1;
    #1;
    chk("to_err_reset", {31'd0, timeout_err}, 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
`endif

    step(2);
    chk("done_count", done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
